// File: rtl/bcd_pkg.sv
// Shared constants for the binary-to-BCD converter: range limit, out-of-range
// display patterns, FSM state encoding and the per-nibble adjust rule.
package bcd_pkg;

  localparam int unsigned BCD_MAX = 32'd9999;
  localparam logic [15:0] BCD_ERR = 16'hEEEE;
  localparam logic [15:0] BCD_SAT = 16'h9999;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Double-dabble correction: a digit of 5 or more would exceed 9 after doubling.
  function automatic logic [3:0] bcd_adj3(input logic [3:0] d);
    logic [3:0] r;
    if (d >= 4'd5) begin
      r = d + 4'd3;
    end else begin
      r = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational add-3 correction for one BCD nibble ahead of each shift step.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = bcd_adj3(i_digit);

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-packed-BCD converter, one step per clock.
// Define BIN2BCD_SAT_EN to saturate out-of-range inputs to all nines instead of "EEEE".
module bin2bcd_seq #(
  parameter int IN_W   = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_W-1:0]       in_bin,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd_out
);

  import bcd_pkg::*;

  localparam int BCD_W = 4 * DIGITS;
  localparam int SH_W  = BCD_W + IN_W;
  localparam int CNT_W = $clog2(IN_W + 1);

`ifdef BIN2BCD_SAT_EN
  localparam logic [3:0] OOR_NIB = BCD_SAT[3:0];
`else
  localparam logic [3:0] OOR_NIB = BCD_ERR[3:0];
`endif
  localparam logic [BCD_W-1:0] OOR_PAT = {DIGITS{OOR_NIB}};

  logic [1:0]       r_state;
  logic [SH_W-1:0]  r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rng;
  logic             r_busy;
  logic             r_done;
  logic             r_ovf;
  logic [BCD_W-1:0] r_bcd;

  logic [1:0]       w_state_nxt;
  logic [BCD_W-1:0] w_adj;
  logic [SH_W-1:0]  w_shift_nxt;
  logic             w_in_oor;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_shift[IN_W + 4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

  assign w_shift_nxt = {w_adj[BCD_W-2:0], r_shift[IN_W-1:0], 1'b0};
  assign w_in_oor    = (32'(in_bin) > BCD_MAX);

  // Next-state selection; SHIFT exits after the step that takes the counter to zero.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SHIFT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs; bcd_out only moves on the DONE edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_rng   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_bcd   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_shift <= {{BCD_W{1'b0}}, in_bin};
            r_cnt   <= CNT_W'(IN_W);
            r_rng   <= w_in_oor;
            r_busy  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          r_shift <= w_shift_nxt;
          r_cnt   <= r_cnt - CNT_W'(1);
        end
        ST_DONE: begin
          r_bcd  <= r_rng ? OOR_PAT : r_shift[SH_W-1:IN_W];
          r_ovf  <= r_rng;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign ovf     = r_ovf;
  assign bcd_out = r_bcd;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomized self-checking bench for bin2bcd_seq against a decimal-arithmetic reference.
module tb_bin2bcd_seq;

  localparam int IN_W   = 14;
  localparam int DIGITS = 4;
  localparam int BW     = 4 * DIGITS;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [IN_W-1:0] in_bin;
  logic            busy;
  logic            done;
  logic            ovf;
  logic [BW-1:0]   bcd_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [BW-1:0] exp_bcd;
  logic          exp_ovf;

  bin2bcd_seq #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .in_bin  (in_bin),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf),
    .bcd_out (bcd_out)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits by division, fixed pattern for values above 9999.
  function automatic logic [15:0] ref_bcd(input int v);
    if (v > 9999) begin
`ifdef BIN2BCD_SAT_EN
      return 16'h9999;
`else
      return 16'hEEEE;
`endif
    end
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // poke_kind: 0 none, 1 stray start at busy cycle poke_cyc, 2 reset at busy cycle poke_cyc
  task automatic run_conv(input int v, input int poke_cyc, input int poke_kind);
    int edges;
    int busy_cyc;
    bit seen;
    @(negedge clk);
    start  = 1'b1;
    in_bin = IN_W'(v);
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    in_bin = IN_W'($urandom);
    check_val("busy_after_accept", 32'(busy), 32'd1);
    check_val("no_done_at_accept", 32'(done), 32'd0);
    edges    = 0;
    busy_cyc = 1;
    seen     = 1'b0;
    while (edges < 40 && !seen) begin
      if (poke_kind == 1 && busy_cyc == poke_cyc) begin
        start  = 1'b1;
        in_bin = IN_W'(55);
      end
      if (poke_kind == 2 && busy_cyc == poke_cyc) begin
        rst_n = 1'b0;
        #1;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_ovf", 32'(ovf), 32'd0);
        check_val("rst_bcd", 32'(bcd_out), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (done) check_val("no_done_after_abort", 32'(done), 32'd0);
        end
        check_val("idle_after_abort", 32'(busy), 32'd0);
        exp_bcd = '0;
        exp_ovf = 1'b0;
        return;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busy_cyc++;
        if (bcd_out !== exp_bcd) check_val("bcd_held_while_busy", 32'(bcd_out), 32'(exp_bcd));
      end
    end
    exp_bcd = ref_bcd(v);
    exp_ovf = (v > 9999);
    check_val("done_seen", 32'(seen), 32'd1);
    check_val("latency", 32'(edges), 32'(IN_W + 1));
    check_val("busy_cycles", 32'(busy_cyc), 32'(IN_W + 1));
    check_val("busy_low_at_done", 32'(busy), 32'd0);
    check_val("bcd_result", 32'(bcd_out), 32'(exp_bcd));
    check_val("ovf_result", 32'(ovf), 32'(exp_ovf));
    @(negedge clk);
    check_val("done_single_pulse", 32'(done), 32'd0);
    check_val("bcd_hold_after", 32'(bcd_out), 32'(exp_bcd));
  endtask

  initial begin
    int cyc;
    int last_done;
    int n_done;
    rst_n   = 1'b0;
    start   = 1'b0;
    in_bin  = '0;
    exp_bcd = '0;
    exp_ovf = 1'b0;
    #1;
    check_val("reset_busy", 32'(busy), 32'd0);
    check_val("reset_done", 32'(done), 32'd0);
    check_val("reset_ovf", 32'(ovf), 32'd0);
    check_val("reset_bcd", 32'(bcd_out), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_conv(1234, 0, 0);
    run_conv(0, 0, 0);
    run_conv(9999, 0, 0);
    run_conv(10000, 0, 0);
    run_conv(16383, 0, 0);
    run_conv(4321, 5, 1);
    run_conv(42, 0, 0);
    run_conv(8765, 7, 2);
    run_conv(8765, 0, 0);

    for (int i = 0; i < 12; i++) begin
      run_conv(int'($urandom_range(0, 16383)), 0, 0);
    end

    // Continuous start: one result every IN_W+2 cycles, value stable throughout.
    @(negedge clk);
    start     = 1'b1;
    in_bin    = IN_W'(999);
    cyc       = 0;
    last_done = -1;
    n_done    = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done) begin
        if (last_done >= 0) check_val("held_start_period", 32'(cyc - last_done), 32'(IN_W + 2));
        last_done = cyc;
        n_done++;
      end
      if (n_done > 0 && bcd_out !== 16'h0999) check_val("held_start_bcd", 32'(bcd_out), 32'h0999);
    end
    start = 1'b0;
    check_val("held_start_done_count", 32'(n_done), 32'd5);
    check_val("held_start_bcd_final", 32'(bcd_out), 32'h0999);
    check_val("held_start_ovf", 32'(ovf), 32'd0);
    repeat (20) @(negedge clk);
    check_val("held_start_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-packed-BCD converter that uses the shift-and-add-3 (double-dabble) method.
- Sits directly upstream of the 4-digit seven-segment display multiplexer.
- Its 16-bit bcd_out drives the multiplexer's in_num, so the display shows decimal 0000–9999 instead of hex.
- One conversion step per clock; the last valid result is held stable between conversions.

Parameters:
- IN_W, 14, width of the binary input; 14 bits covers 0..16383.
- DIGITS, 4, number of BCD digits produced; bcd_out width is 4*DIGITS.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  conversion request; sampled only in IDLE.
- in_bin  input  IN_W  binary value; captured on the edge that accepts start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd_out has just been updated.
- ovf  output  1  set if the last accepted in_bin was greater than 9999.
- bcd_out  output  4*DIGITS  packed BCD, digit 3 in [15:12], held between conversions.

Behaviour:
- Reset: clk, single clock domain; rst_n is asynchronous and active-low.
  - While rst_n is low: state=IDLE, busy=0, done=0, ovf=0, bcd_out=0, shift counter=0.
  - Asserting reset mid-conversion aborts it; no done pulse follows.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE → SHIFT when start=1 at edge E0.
    - The register {bcd=0, bin=in_bin} is loaded.
    - The range flag (in_bin > 9999) is captured.
    - cnt is set to IN_W; busy rises.
  - SHIFT, edges E1..E_IN_W, one step per edge:
    - Each BCD nibble ≥5 gets +3 (4-bit add, no carry out of the nibble).
    - The combined {bcd,bin} register is then shifted left by 1.
    - cnt is decremented; after the step where cnt reaches 1, go to DONE.
  - DONE, edge E_{IN_W+1}:
    - bcd_out is loaded with the result, or the out-of-range pattern (see Optional Feature).
    - ovf is loaded with the captured range flag.
    - done rises and busy falls on this same edge; next state IDLE.
  - At edge E_{IN_W+2}, done=0.
- Latency: done is high in the cycle after edge E_{IN_W+1}, i.e. 15 edges after acceptance at default IN_W=14.
- Latency is fixed; it does not depend on the data and applies to out-of-range inputs as well.
- start while busy: ignored; no queuing.
- start held high continuously: back-to-back conversions with one IDLE cycle between them (throughput of 1 per IN_W+2 cycles).
- in_bin changes after E0 have no effect on the conversion in flight.
- bcd_out changes only at the DONE edge, so the display never sees intermediate values.

Optional Feature:
- Macro: BIN2BCD_SAT_EN.
- Defined: an out-of-range input (>9999) produces bcd_out=16'h9999 (saturate) and ovf=1.
- Undefined: an out-of-range input produces bcd_out=16'hEEEE (display shows "EEEE") and ovf=1.
- In-range behaviour is identical either way.

Decomposition:
- Package bcd_pkg:
  - BCD_MAX=9999
  - BCD_ERR=16'hEEEE
  - BCD_SAT=16'h9999
  - FSM state encoding: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2
- Sub-module bcd_digit_adj: combinational per-nibble adjust (d≥5 ? d+3 : d), instantiated DIGITS times.

Test Plan:
- Reset, then start=1 for one cycle with in_bin=1234 → busy for 15 cycles; done pulse; bcd_out=16'h1234, ovf=0.
- in_bin=0, then in_bin=9999 → bcd_out=16'h0000, then 16'h9999; ovf=0 both times; exactly one done pulse per conversion.
- in_bin=10000 → ovf=1; bcd_out=16'hEEEE without BIN2BCD_SAT_EN and 16'h9999 with it; latency unchanged.
- Convert 4321, then pulse start with in_bin=55 at the 5th busy cycle → ignored; result 16'h4321; a single done pulse.
- Convert 42, then start 8765 and drop rst_n at the 7th busy cycle → all outputs 0 immediately; no done pulse; the next conversion of 8765 yields 16'h8765.
- start held high with in_bin=999 → done every 16 cycles; bcd_out stays at 16'h0999 throughout.
